// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end between the ALU result and a word-addressed data memory
// with synchronous read.
// It handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores are done as read-modify-write.
// Loads get lane extraction and sign/zero extension. Misaligned accesses and illegal funct3
// values are rejected with an error response.
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake (ready only in idle)
//   req_store, req_funct3       operation select
//   req_addr, req_wdata         byte address, store data
//   resp_valid/rdata/err        one-cycle completion pulse with load data / error flag
//   mem_addr/re/we/wdata/rdata  word-wide data memory port, rdata one cycle after re
module load_store_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StMerge, StResp} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        funct_ok, misaligned, illegal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  // Legality of the incoming request, evaluated only when it is accepted.
  always_comb begin
    if (req_store) funct_ok = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
    else           funct_ok = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal    = !funct_ok || misaligned;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = illegal;
          if (illegal)                                     state_d = StResp;
          else if (req_store && req_funct3[1:0] == 2'b10)  state_d = StWrite;
          else                                             state_d = StRead;
        end
      end
      StWrite: state_d = StResp;
      StRead:  state_d = StMerge;
      StMerge: begin
        if (!store_q) rdata_d = load_val;
        state_d = StResp;
      end
      StResp: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes are decoded from state so an async reset kills them immediately.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid ? err_q : 1'b0;
    mem_addr   = addr_q[ADDR_W-1:2];
    mem_re     = (state_q == StRead);
    mem_we     = (state_q == StWrite) || ((state_q == StMerge) && store_q);
    mem_wdata  = 32'h0;
    if (state_q == StWrite)                 mem_wdata = wdata_q;
    else if (state_q == StMerge && store_q) mem_wdata = merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [5:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory; the bench preloads words through the poke port.
  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'h0;
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (poke_en) mem[poke_idx] <= poke_val;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int re_cnt = 0, we_cnt = 0, resp_cnt = 0;
  int last_re_cyc = 0, last_we_cyc = 0;
  logic [5:0]  last_we_addr;
  logic [31:0] last_we_data;
  logic [32:0] sb_q [$];  // {err, rdata}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder and response scoreboard.
  always @(negedge clk) begin
    if (mem_re) begin re_cnt++; last_re_cyc = cyc; end
    if (mem_we) begin
      we_cnt++; last_we_cyc = cyc; last_we_addr = mem_addr; last_we_data = mem_wdata;
    end
    if (resp_valid) begin
      logic [32:0] e;
      resp_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e[32]});
        chk("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One request with expected response, latency (negedges after acceptance) and strobe counts.
  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [7:0] a, input logic [31:0] wd, input logic e,
                       input logic [31:0] rd, input int lat, input int n_re, input int n_we);
    int n, re0, we0, acc;
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    re0 = re_cnt; we0 = we_cnt;
    sb_q.push_back({e, rd});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    n = 1;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_re_count"}, re_cnt - re0, n_re);
    chk({tag, "_we_count"}, we_cnt - we0, n_we);
    if (n_re > 0) chk({tag, "_re_cycle"}, last_re_cyc - acc, 0);
    if (n_we > 0) chk({tag, "_we_cycle"}, last_we_cyc - acc, n_re);
    @(negedge clk);
    chk({tag, "_idle_valid"}, {31'h0, resp_valid}, 32'd0);
    chk({tag, "_idle_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_idle_err"}, {31'h0, resp_err}, 32'd0);
  endtask

  logic [2:0]  bb_f3 [3];
  logic [7:0]  bb_a [3];
  logic [31:0] bb_exp [3];

  initial begin
    int n, c0;
    // Reset state
    #2;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'h0, mem_re}, 32'd0);
    chk("rst_mem_addr", {26'h0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    poke(6'd1, 32'h8000F0FF);

    // SW
    issue("sw", 1'b1, 3'b010, 8'h08, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1);
    chk("sw_addr", {26'h0, last_we_addr}, 32'd2);
    chk("sw_wdata", last_we_data, 32'hDEADBEEF);
    chk("sw_mem", mem[2], 32'hDEADBEEF);

    // SB read-modify-write
    poke(6'd2, 32'h11223344);
    issue("sb", 1'b1, 3'b000, 8'h09, 32'h000000AA, 1'b0, 32'h0, 3, 1, 1);
    chk("sb_addr", {26'h0, last_we_addr}, 32'd2);
    chk("sb_wdata", last_we_data, 32'h1122AA44);
    chk("sb_mem", mem[2], 32'h1122AA44);

    // SH upper half
    issue("sh", 1'b1, 3'b001, 8'h0A, 32'hFFFF5566, 1'b0, 32'h0, 3, 1, 1);
    chk("sh_mem", mem[2], 32'h5566AA44);

    // Loads from 0x8000F0FF
    issue("lb", 1'b0, 3'b000, 8'h04, 32'h0, 1'b0, 32'hFFFFFFFF, 3, 1, 0);
    issue("lbu", 1'b0, 3'b100, 8'h05, 32'h0, 1'b0, 32'h000000F0, 3, 1, 0);
    issue("lh", 1'b0, 3'b001, 8'h06, 32'h0, 1'b0, 32'hFFFF8000, 3, 1, 0);
    issue("lhu", 1'b0, 3'b101, 8'h06, 32'h0, 1'b0, 32'h00008000, 3, 1, 0);
    issue("lw", 1'b0, 3'b010, 8'h04, 32'h0, 1'b0, 32'h8000F0FF, 3, 1, 0);
    issue("lb7", 1'b0, 3'b000, 8'h07, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1, 0);

    // Illegal requests
    issue("lw_mis", 1'b0, 3'b010, 8'h05, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    issue("sh_mis", 1'b1, 3'b001, 8'h03, 32'h12345678, 1'b1, 32'h0, 1, 0, 0);
    issue("st_f3", 1'b1, 3'b100, 8'h04, 32'h12345678, 1'b1, 32'h0, 1, 0, 0);
    issue("ld_f3", 1'b0, 3'b011, 8'h00, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    chk("illegal_mem", mem[1], 32'h8000F0FF);

    // Reset during MERGE of an SB
    poke(6'd3, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 8'h0C;
    req_wdata = 32'h000000BB;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstm_we_before", {31'h0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstm_we_after", {31'h0, mem_we}, 32'd0);
    chk("rstm_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_mem", mem[3], 32'h55667788);
    chk("rstm_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rstm_rdata", resp_rdata, 32'h0);
    chk("rstm_err", {31'h0, resp_err}, 32'd0);

    // Back-to-back loads with req_valid held high
    bb_f3[0] = 3'b000; bb_a[0] = 8'h04; bb_exp[0] = 32'hFFFFFFFF;
    bb_f3[1] = 3'b101; bb_a[1] = 8'h06; bb_exp[1] = 32'h00008000;
    bb_f3[2] = 3'b010; bb_a[2] = 8'h0C; bb_exp[2] = 32'h55667788;
    c0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = bb_f3[i]; req_addr = bb_a[i];
      req_wdata = 32'h0;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("bb_ready_timeout", 32'd1, 32'd0);
      sb_q.push_back({1'b0, bb_exp[i]});
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
    chk("bb_drained", sb_q.size(), 0);
    chk("bb_resp_count", resp_cnt - c0, 3);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Byte-addressed load/store front end between the execute stage's ALU result and the word-addressed, synchronous-read data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses:
  - read-modify-write for sub-word stores;
  - lane extraction and sign/zero extension for loads;
  - alignment and funct3 checking.
- Uses a valid/ready request handshake and produces a one-cycle response pulse.

Parameters:
ADDR_W, 8, byte address width; memory word index is addr[ADDR_W-1:2].

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_store  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (low bytes used for SB/SH)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3; valid with resp_valid
mem_addr  output  ADDR_W-2  word index to data memory
mem_re  output  1  word read strobe; mem_rdata valid next cycle
mem_we  output  1  word write strobe, written at the rising edge
mem_wdata  output  32  full word to write
mem_rdata  input  32  word read data, one cycle after mem_re

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0;
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - req_ready=1 once in IDLE.
  - Reset mid-operation abandons the access. mem_we/mem_re are decoded from state and drop immediately. No partial write occurs after reset assertion.
- Acceptance: when req_valid & req_ready at edge T, latch store, funct3, addr and wdata. req_ready=0 until the unit returns to IDLE. Only one request is outstanding.
- Legality:
  - Loads: funct3 in {000,001,010,100,101}.
  - Stores: funct3 in {000,001,010}.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
  - Any violation: go directly to RESP with err=1. No memory strobe is issued. Response pulse at T+1.
- States and transitions:
  - IDLE: accept.
    - Illegal request -> RESP.
    - SW -> WRITE.
    - Any load, SB or SH -> READ.
  - WRITE (T+1): mem_we=1, mem_wdata=req_wdata -> RESP. Response at T+2.
  - READ (T+1): mem_re=1 -> MERGE.
  - MERGE (T+2): mem_rdata is valid.
    - Load: register the extracted result -> RESP.
    - SB/SH: mem_we=1. mem_wdata = mem_rdata with the target lane(s) replaced by req_wdata[7:0] or req_wdata[15:0] -> RESP.
    - Response at T+3.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready=1 in the following cycle, so back-to-back requests are accepted every 3-4 cycles.
- Address and lanes:
  - mem_addr = latched addr[ADDR_W-1:2], held stable from the cycle after acceptance through MERGE.
  - Lanes are little-endian: byte k = bits [8k+7:8k]; halfword at addr[1]*16.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Output timing: resp_rdata and resp_err hold their values only while resp_valid=1 and return to 0 in IDLE. There is no response backpressure; the consumer must take the pulse.
- Request inputs are ignored outside IDLE.
- Top word (addr all-ones region) has no special wrap handling; the index is truncated to ADDR_W-2 bits.

Test Plan:
- Reset: assert rst mid-MERGE of an SB -> mem_we drops the same cycle and memory is unchanged. After release: req_ready=1, all responses 0.
- SW addr=0x08, wdata=0xDEADBEEF -> mem_we at T+1, mem_addr=2, mem_wdata=0xDEADBEEF. resp_valid at T+2 with err=0, rdata=0.
- SB addr=0x09, wdata=0x000000AA over word 0x11223344 -> mem_re T+1, then at T+2 mem_we with mem_wdata=0x1122AA44. resp at T+3.
- Loads of word 0x8000F0FF at addr 4..7:
  - LB addr=4 -> 0xFFFFFFFF.
  - LBU addr=5 -> 0x000000F0.
  - LH addr=6 -> 0xFFFF8000.
  - LHU addr=6 -> 0x00008000.
  - LW addr=4 -> 0x8000F0FF.
- Illegal requests each give a resp at T+1 with err=1, rdata=0, and no mem_re/mem_we:
  - LW addr=0x05;
  - SH addr=0x03;
  - store funct3=100.
- Back-to-back: hold req_valid high with 3 queued loads -> each accepted only when req_ready=1. Responses arrive in order with no overlap and no dropped request.
